// File: rtl/stream_mux_nx1.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_nx1
// Purpose  : N:1 valid/ready stream multiplexer with a 1-deep registered
//            output stage. The channel is chosen either by an external select
//            (MODE=0) or by an internal round-robin arbiter (MODE=1).
// Ports    : clk, rst       - clock (rising edge), asynchronous active-high reset
//            in_data        - N_CH packed words, channel i at [i*WIDTH +: WIDTH]
//            in_valid       - per-channel word-present flags
//            in_ready       - per-channel accept strobes (one-hot or zero)
//            sel            - channel select, only used when MODE=0
//            out_data       - registered output word
//            out_ch         - channel index the held word came from
//            out_valid      - output register holds a word
//            out_ready      - consumer accepts the held word
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_nx1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] C_N_CH = (SEL_W+1)'(N_CH);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;

  logic             w_load;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant;
  logic             w_xfer_in;
  logic [WIDTH-1:0] w_sel_data;

  // The output register can take a word whenever it is empty or being drained.
  assign w_load = !r_out_valid || out_ready;

  if (MODE == 1) begin : g_mode_rr
    logic [SEL_W-1:0] r_rr_ptr;

    // Scan from the farthest candidate down to the nearest so the nearest
    // requesting channel after r_rr_ptr ends up as the winner.
    always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = '0;
      for (int k = N_CH; k >= 1; k--) begin
        if (in_valid[(int'(r_rr_ptr) + k) % N_CH]) begin
          w_grant_vld = 1'b1;
          w_grant     = SEL_W'((int'(r_rr_ptr) + k) % N_CH);
        end
      end
    end

    // Pointer only advances on an accepted word, so idle and stalled cycles
    // leave the fairness order untouched.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rr_ptr <= SEL_W'(N_CH - 1);
      end else if (w_xfer_in) begin
        r_rr_ptr <= w_grant;
      end
    end
  end else begin : g_mode_sel
    // Out-of-range select values grant nothing.
    assign w_grant     = sel;
    assign w_grant_vld = ({1'b0, sel} < C_N_CH);
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = w_grant_vld && (w_grant == SEL_W'(i)) && w_load && !rst;
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer_in = |(in_valid & in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_xfer_in) begin
      // A new word replaces the drained one in the same cycle: no bubble.
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_nx1.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_nx1
// Purpose  : Directed self-checking bench for stream_mux_nx1. Three instances:
//            A = 4 channels, external select; B = 4 channels, round-robin;
//            C = 3 channels, external select (out-of-range select case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_nx1;

  logic clk;
  logic rst;

  // Instance A: N_CH=4, MODE=0
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_ch;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_ready;
  // Instance B: N_CH=4, MODE=1
  logic [31:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_ch;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready;
  // Instance C: N_CH=3, MODE=0
  logic [23:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [1:0]  c_sel, c_out_ch;
  logic [7:0]  c_out_data;
  logic        c_out_valid, c_out_ready;

  int checks = 0;
  int errors = 0;

  stream_mux_nx1 #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready));

  stream_mux_nx1 #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready));

  stream_mux_nx1 #(.N_CH(3), .WIDTH(8), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 4'hF; b_in_valid = 4'hF; c_in_valid = 3'h7;
    a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    a_in_data = 32'h44A52211; b_in_data = 32'h13121110; c_in_data = 24'hC2C1C0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_a_data got %h exp 00", a_out_data); end
    checks++; if (a_out_ch !== 2'd0) begin errors++; $display("FAIL rst_a_ch got %0d exp 0", a_out_ch); end
    checks++; if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL rst_a_in_ready got %b exp 0000", a_in_ready); end
    checks++; if (b_in_ready !== 4'b0000) begin errors++; $display("FAIL rst_b_in_ready got %b exp 0000", b_in_ready); end
    tick();
    checks++; if (b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_ch !== 2'd0)
      begin errors++; $display("FAIL rst_b_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", b_out_valid, b_out_data, b_out_ch); end
    checks++; if (c_in_ready !== 3'b000) begin errors++; $display("FAIL rst_c_in_ready got %b exp 000", c_in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (b_in_ready !== 4'b0001) begin errors++; $display("FAIL rst_b_first_grant got %b exp 0001", b_in_ready); end
    checks++; if (a_in_ready !== 4'b0001) begin errors++; $display("FAIL rst_a_sel0 got %b exp 0001", a_in_ready); end
    a_in_valid = 4'h0; b_in_valid = 4'h0; c_in_valid = 3'h0;
    tick();
  endtask

  task automatic test_select();
    a_sel = 2'd2; a_in_valid = 4'b0100; a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 4'b0100) begin errors++; $display("FAIL sel2_in_ready got %b exp 0100", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5 || a_out_ch !== 2'd2)
      begin errors++; $display("FAIL sel2_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", a_out_valid, a_out_data, a_out_ch); end
    a_in_valid = 4'b0000;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL sel2_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_select_no_valid();
    a_sel = 2'd3; a_in_valid = 4'b0000;
    c_sel = 2'd3; c_in_valid = 3'b111;
    #1;
    checks++; if (a_in_ready !== 4'b1000) begin errors++; $display("FAIL sel3_a_in_ready got %b exp 1000", a_in_ready); end
    checks++; if (c_in_ready !== 3'b000) begin errors++; $display("FAIL sel3_c_in_ready got %b exp 000", c_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL sel3_a_valid got %b exp 0", a_out_valid); end
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL sel3_c_valid got %b exp 0", c_out_valid); end
    c_sel = 2'd1;
    #1;
    checks++; if (c_in_ready !== 3'b010) begin errors++; $display("FAIL sel1_c_in_ready got %b exp 010", c_in_ready); end
    tick();
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'hC1 || c_out_ch !== 2'd1)
      begin errors++; $display("FAIL sel1_c_out got v=%b d=%h ch=%0d exp v=1 d=c1 ch=1", c_out_valid, c_out_data, c_out_ch); end
    c_in_valid = 3'b000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [1:0] exp_ch;
    b_in_valid = 4'b1111; b_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_ch  = 2'(k % 4);
      exp_rdy = 4'b0001 << exp_ch;
      #1;
      checks++; if (b_in_ready !== exp_rdy) begin errors++; $display("FAIL rr_in_ready[%0d] got %b exp %b", k, b_in_ready, exp_rdy); end
      tick();
      checks++; if (b_out_valid !== 1'b1 || b_out_ch !== exp_ch || b_out_data !== (8'h10 + 8'(exp_ch)))
        begin errors++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", k, b_out_valid, b_out_ch, b_out_data, exp_ch, 8'h10 + 8'(exp_ch)); end
    end
    b_in_valid = 4'b0000;
    tick();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", b_out_valid); end
  endtask

  task automatic test_backpressure();
    a_sel = 2'd3; a_in_data = 32'h33A52211; a_in_valid = 4'b1000; a_out_ready = 1'b0;
    tick();
    // Switch source while stalled: the held word must not change.
    a_sel = 2'd1; a_in_data = 32'h4444551F; a_in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      checks++; if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0000", k, a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h33 || a_out_ch !== 2'd3)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=33 ch=3", k, a_out_valid, a_out_data, a_out_ch); end
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_in_ready got %b exp 0010", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h55 || a_out_ch !== 2'd1)
      begin errors++; $display("FAIL bp_next got v=%b d=%h ch=%0d exp v=1 d=55 ch=1", a_out_valid, a_out_data, a_out_ch); end
    a_in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    // rr pointer is at ch1 after the round-robin run; request ch2 only.
    b_in_valid = 4'b0100; b_out_ready = 1'b0;
    tick();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h12 || b_out_ch !== 2'd2)
      begin errors++; $display("FAIL rs_load got v=%b d=%h ch=%0d exp v=1 d=12 ch=2", b_out_valid, b_out_data, b_out_ch); end
    b_in_valid = 4'b1111;
    #1;
    checks++; if (b_in_ready !== 4'b0000) begin errors++; $display("FAIL rs_stall_in_ready got %b exp 0000", b_in_ready); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rs_async_valid got %b exp 0", b_out_valid); end
    checks++; if (b_in_ready !== 4'b0000) begin errors++; $display("FAIL rs_in_ready got %b exp 0000", b_in_ready); end
    tick();
    rst = 1'b0; b_out_ready = 1'b1;
    #1;
    checks++; if (b_in_ready !== 4'b0001) begin errors++; $display("FAIL rs_first_grant got %b exp 0001", b_in_ready); end
    tick();
    checks++; if (b_out_valid !== 1'b1 || b_out_ch !== 2'd0 || b_out_data !== 8'h10)
      begin errors++; $display("FAIL rs_first_out got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", b_out_valid, b_out_ch, b_out_data); end
    b_in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_skip();
    // Pointer now at ch0; only ch1 and ch3 request.
    b_in_valid = 4'b1010;
    #1;
    checks++; if (b_in_ready !== 4'b0010) begin errors++; $display("FAIL skip_rdy1 got %b exp 0010", b_in_ready); end
    tick();
    checks++; if (b_out_ch !== 2'd1 || b_out_data !== 8'h11) begin errors++; $display("FAIL skip_out1 got ch=%0d d=%h exp ch=1 d=11", b_out_ch, b_out_data); end
    checks++; if (b_in_ready !== 4'b1000) begin errors++; $display("FAIL skip_rdy3 got %b exp 1000", b_in_ready); end
    tick();
    checks++; if (b_out_ch !== 2'd3 || b_out_data !== 8'h13) begin errors++; $display("FAIL skip_out3 got ch=%0d d=%h exp ch=3 d=13", b_out_ch, b_out_data); end
    b_in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_select();
    test_select_no_valid();
    test_round_robin();
    test_backpressure();
    test_reset_mid_stall();
    test_rr_skip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
